norm_mean_var: RTL

NORM_MEAN_VAR -- requirements
Module: norm_mean_var

---
 rtl/norm_pkg.sv | 11 +
 rtl/norm_square.sv | 14 +
 rtl/norm_mean_var.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/norm_pkg.sv
// Shared FSM state type for the norm_mean_var block.
package norm_pkg;

  typedef enum logic [1:0] {
    ACCUM     = 2'd0,
    CALC_MEAN = 2'd1,
    CALC_VAR  = 2'd2,
    DONE      = 2'd3
  } norm_state_e;

endpackage

// File: rtl/norm_square.sv
// Squares a W-bit signed value; the result is always non-negative and fits in 2W bits.
module norm_square #(
  parameter int W = 8
) (
  input  logic [W-1:0]   i_x,
  output logic [2*W-1:0] o_sq
);

  logic signed [2*W-1:0] w_ext;

  assign w_ext = {{W{i_x[W-1]}}, i_x};
  assign o_sq  = w_ext * w_ext;

endmodule

// File: rtl/norm_mean_var.sv
// Block mean and variance over K = 2**LOG2K signed samples.
// Define NORM_VAR_EN to build the sum-of-squares and variance path; without it var_out is 0.
module norm_mean_var
  import norm_pkg::*;
#(
  parameter int W     = 8,
  parameter int LOG2K = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           clear,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   mean_out,
  output logic [2*W-1:0] var_out
);

  localparam int SW = W + LOG2K;
  localparam int VW = 2 * W;
  localparam int QW = VW + LOG2K;
  localparam logic [LOG2K-1:0] LAST_CNT = '1;

  norm_state_e          r_state;
  norm_state_e          w_state_nxt;
  logic signed [SW-1:0] r_sum;
  logic [LOG2K-1:0]     r_count;
  logic signed [W-1:0]  r_mean;
  logic                 r_out_valid;
  logic                 w_accept;
  logic                 w_last;
  logic                 w_handshake;
  logic                 w_load_mean;

  // A sample offered while clear is high is dropped.
  assign w_accept    = in_valid & in_ready & ~clear;
  assign w_last      = (r_count == LAST_CNT);
  assign w_handshake = r_out_valid & out_ready;

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ACCUM;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    if (clear) begin
      w_state_nxt = ACCUM;
    end else begin
      case (r_state)
        ACCUM:     w_state_nxt = (w_accept && w_last) ? CALC_MEAN : ACCUM;
        CALC_MEAN: w_state_nxt = CALC_VAR;
        CALC_VAR:  w_state_nxt = DONE;
        DONE:      w_state_nxt = out_ready ? ACCUM : DONE;
        default:   w_state_nxt = ACCUM;
      endcase
    end
  end

  // State-decoded outputs and load enables
  always_comb begin
    in_ready    = 1'b0;
    w_load_mean = 1'b0;
    case (r_state)
      ACCUM:     in_ready    = 1'b1;
      CALC_MEAN: w_load_mean = ~clear;
      default: begin
        in_ready    = 1'b0;
        w_load_mean = 1'b0;
      end
    endcase
  end

  // Running sum and sample count; the count wraps to 0 on the K-th sample
  always_ff @(posedge clk) begin
    if (!reset || clear || w_handshake) begin
      r_sum   <= '0;
      r_count <= '0;
    end else if (w_accept) begin
      r_sum   <= r_sum + SW'(signed'(in_data));
      r_count <= r_count + LOG2K'(1);
    end
  end

  // out_valid tracks DONE one edge ahead so it is a clean register
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= (w_state_nxt == DONE);
    end
  end

  // Floor mean via arithmetic shift
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_mean <= '0;
    end else if (w_load_mean) begin
      r_mean <= W'(r_sum >>> LOG2K);
    end
  end

`ifdef NORM_VAR_EN
  logic [VW-1:0] w_sample_sq;
  logic [VW-1:0] w_mean_sq;
  logic [QW-1:0] r_sumsq;
  logic [VW-1:0] r_ex2;
  logic [VW-1:0] r_var;
  logic [VW:0]   w_var_diff;
  logic          w_load_var;

  norm_square #(.W(W)) u_sq_sample (.i_x(in_data), .o_sq(w_sample_sq));
  norm_square #(.W(W)) u_sq_mean   (.i_x(r_mean),  .o_sq(w_mean_sq));

  assign w_load_var = (r_state == CALC_VAR) & ~clear;
  // Extra top bit flags a negative E[x^2] - mean^2 caused by the floored mean.
  assign w_var_diff = {1'b0, r_ex2} - {1'b0, w_mean_sq};

  // Sum of squares, cleared together with the running sum
  always_ff @(posedge clk) begin
    if (!reset || clear || w_handshake) begin
      r_sumsq <= '0;
    end else if (w_accept) begin
      r_sumsq <= r_sumsq + QW'(w_sample_sq);
    end
  end

  // E[x^2] alongside the mean, then the clamped variance one state later
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_ex2 <= '0;
      r_var <= '0;
    end else begin
      if (w_load_mean) begin
        r_ex2 <= VW'(r_sumsq >> LOG2K);
      end
      if (w_load_var) begin
        r_var <= w_var_diff[VW] ? '0 : w_var_diff[VW-1:0];
      end
    end
  end

  assign var_out = r_var;
`else
  assign var_out = '0;
`endif

  assign mean_out  = r_mean;
  assign out_valid = r_out_valid;

endmodule
